memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter ADDRESS_SIZE, default 12, byte-address width.
REQ-002 Parameter CACHE_LINE_SIZE, default 128, line width in bits.
REQ-003 Parameter LATENCY, default 5, range 1..255, wait cycles before the memory access.
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ic_req  in  1  instruction-cache read request; held high until ic_ready.
REQ-007 ic_addr  in  ADDRESS_SIZE  instruction-cache line address.
REQ-008 ic_ready  out  1  one-cycle pulse; ic_data valid.
REQ-009 ic_data  out  CACHE_LINE_SIZE  line returned to the instruction cache.
REQ-010 dc_req  in  1  data-cache request; held high until dc_ready.
REQ-011 dc_we  in  1  1 = writeback line, 0 = fill read.
REQ-012 dc_addr  in  ADDRESS_SIZE  data-cache line address.
REQ-013 dc_wdata  in  CACHE_LINE_SIZE  writeback line.
REQ-014 dc_ready  out  1  one-cycle completion pulse for reads and writes.
REQ-015 dc_data  out  CACHE_LINE_SIZE  line returned to the data cache.
REQ-016 mem_write_enable, mem_read_enable  out  1 each  memory strobes.
REQ-017 mem_address  out  ADDRESS_SIZE  memory line address.
REQ-018 mem_data_in  out  CACHE_LINE_SIZE  line to memory.
REQ-019 mem_data_out  in  CACHE_LINE_SIZE  registered memory read data, valid one cycle after mem_read_enable.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, WAIT, ACCESS, RESPOND, DONE; one transaction in flight at a time.
REQ-022 IDLE: if dc_req, accept data cache; else if ic_req, accept instruction cache; else stay IDLE.
REQ-023 Data cache has fixed priority: on simultaneous requests the instruction cache waits.
REQ-024 On accept, latch owner, dc_we (0 for instruction cache), address and dc_wdata; go to WAIT with counter = LATENCY-1.
REQ-025 Latched address low log2(CACHE_LINE_SIZE/8) bits are forced to 0 (line-aligned, 0x...0 for 128-bit lines).
REQ-026 Input changes after accept, including req deassertion, are ignored; the transaction completes and ready still pulses.
REQ-027 WAIT: decrement the counter each cycle; go to ACCESS in the cycle after the counter reads 0; WAIT lasts exactly LATENCY cycles.
REQ-028 ACCESS lasts one cycle: assert mem_write_enable if latched we=1, else mem_read_enable; never both.
REQ-029 mem_address and mem_data_in always drive the latched values; strobes are low in all states other than ACCESS.
REQ-030 RESPOND lasts one cycle: for a read, capture mem_data_out into the owner's data register.
REQ-031 DONE lasts one cycle: the owner's ready is 1 and the other ready is 0; then go to IDLE.
REQ-032 Latency: request first seen in cycle 0 (IDLE) -> ready in cycle LATENCY+3 (cycle 8 at default).
REQ-033 IDLE samples requests only in cycles where no ready is high, so a req held across ready is never double-accepted.
REQ-034 ic_data and dc_data hold their last read value until the next read for that owner; writes leave dc_data unchanged.

Reset
REQ-035 Reset forces state IDLE, counter 0, ic_ready=0, dc_ready=0, both strobes 0, busy=0, and ic_data, dc_data, mem_address and mem_data_in to 0.
REQ-036 Reset in any state aborts the transaction without a strobe or ready pulse; a req still high is re-accepted in the first cycle after reset.

Verification
REQ-037 dc read, addr 0x013, LATENCY=5, memory line at 0x010 = 0x00112233445566778899AABBCCDDEEFF -> mem_address=0x010; mem_read_enable high only in cycle 6; dc_ready pulses in cycle 8 with dc_data equal to that line.
REQ-038 dc write, addr 0x020, data 0xA5 repeated -> mem_write_enable high only in cycle 6; dc_ready pulses in cycle 8; a later read of 0x020 returns the 0xA5 line.
REQ-039 ic_req and dc_req both rise in cycle 0 -> dc served first (dc_ready in cycle 8); ic accepted in cycle 9; ic_ready in cycle 17.
REQ-040 reset asserted in cycle 4 of a dc read -> no mem_read_enable, no dc_ready; with dc_req held high, the transaction restarts after reset and completes 8 cycles after re-accept.
REQ-041 dc_req deasserted in cycle 2 -> dc_ready still pulses in cycle 8; no second access occurs.
REQ-042 LATENCY=1 -> mem_read_enable in cycle 2; ready in cycle 4.

Source files
------------

// File: rtl/memory_controller_if.sv
// Cache-side and memory-side signal bundle for memory_controller.
// The slave modport is the controller's view; master is the caches/memory view.
interface memory_controller_if #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128
);
  logic                       ic_req;
  logic [ADDRESS_SIZE-1:0]    ic_addr;
  logic                       ic_ready;
  logic [CACHE_LINE_SIZE-1:0] ic_data;

  logic                       dc_req;
  logic                       dc_we;
  logic [ADDRESS_SIZE-1:0]    dc_addr;
  logic [CACHE_LINE_SIZE-1:0] dc_wdata;
  logic                       dc_ready;
  logic [CACHE_LINE_SIZE-1:0] dc_data;

  logic                       mem_write_enable;
  logic                       mem_read_enable;
  logic [ADDRESS_SIZE-1:0]    mem_address;
  logic [CACHE_LINE_SIZE-1:0] mem_data_in;
  logic [CACHE_LINE_SIZE-1:0] mem_data_out;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_data_out,
    output ic_ready, ic_data, dc_ready, dc_data,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_data_out,
    input  ic_ready, ic_data, dc_ready, dc_data,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );
endinterface

// File: rtl/memory_controller.sv
// Arbitrates I-cache and D-cache line requests (D-cache wins) onto one memory port,
// one transaction at a time: IDLE -> WAIT(LATENCY) -> ACCESS -> RESPOND -> DONE.
module memory_controller #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int LATENCY         = 5
) (
  input  logic                clock,
  input  logic                reset,
  memory_controller_if.slave  bus,
  output logic                busy
);

  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK =
    ~((ADDRESS_SIZE'(1) << OFFSET_BITS) - ADDRESS_SIZE'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACCESS, S_RESPOND, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       owner_dc_q, owner_dc_d;
  logic                       we_q, we_d;
  logic [ADDRESS_SIZE-1:0]    addr_q, addr_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic [CACHE_LINE_SIZE-1:0] ic_data_q, ic_data_d;
  logic [CACHE_LINE_SIZE-1:0] dc_data_q, dc_data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_dc_q <= owner_dc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_dc_d = owner_dc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    case (state_q)
      S_IDLE: begin
        // Ready is only ever high in DONE, so IDLE never sees a stale held request.
        if (bus.dc_req) begin
          owner_dc_d = 1'b1;
          we_d       = bus.dc_we;
          addr_d     = bus.dc_addr & ALIGN_MASK;
          wdata_d    = bus.dc_wdata;
          cnt_d      = 8'(LATENCY - 1);
          state_d    = S_WAIT;
        end else if (bus.ic_req) begin
          owner_dc_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = bus.ic_addr & ALIGN_MASK;
          wdata_d    = bus.dc_wdata;
          cnt_d      = 8'(LATENCY - 1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ACCESS: state_d = S_RESPOND;
      S_RESPOND: begin
        if (!we_q) begin
          if (owner_dc_q) dc_data_d = bus.mem_data_out;
          else            ic_data_d = bus.mem_data_out;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_read_enable  = (state_q == S_ACCESS) && !we_q;
  assign bus.mem_write_enable = (state_q == S_ACCESS) &&  we_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_in      = wdata_q;
  assign bus.dc_ready         = (state_q == S_DONE) &&  owner_dc_q;
  assign bus.ic_ready         = (state_q == S_DONE) && !owner_dc_q;
  assign bus.dc_data          = dc_data_q;
  assign bus.ic_data          = ic_data_q;
  assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench: default-latency controller against a line memory model,
// plus a LATENCY=1 instance for the minimum-latency timing.
module tb_memory_controller;

  localparam logic [127:0] LINE_A  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_1  = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

  logic clock = 1'b0;
  logic reset;
  logic busy0, busy1;

  always #5 clock = ~clock;

  memory_controller_if #(.ADDRESS_SIZE(12), .CACHE_LINE_SIZE(128)) bus0 ();
  memory_controller_if #(.ADDRESS_SIZE(12), .CACHE_LINE_SIZE(128)) bus1 ();

  memory_controller #(.ADDRESS_SIZE(12), .CACHE_LINE_SIZE(128), .LATENCY(5)) u_dut0 (
    .clock (clock), .reset (reset), .bus (bus0), .busy (busy0)
  );
  memory_controller #(.ADDRESS_SIZE(12), .CACHE_LINE_SIZE(128), .LATENCY(1)) u_dut1 (
    .clock (clock), .reset (reset), .bus (bus1), .busy (busy1)
  );

  logic [127:0] mem0 [0:255];

  int n_checks = 0;
  int n_errors = 0;
  int cyc, n_rd, n_wr, n_dcr, n_icr, n_both;
  int first_rd, first_wr, first_dcr, first_icr, first_rd1, first_dcr1;
  logic [11:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  logic         busy_log [0:63];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    cyc = 0; n_rd = 0; n_wr = 0; n_dcr = 0; n_icr = 0;
    first_rd = -1; first_wr = -1; first_dcr = -1; first_icr = -1;
    first_rd1 = -1; first_dcr1 = -1;
    for (int i = 0; i < 64; i++) busy_log[i] = 1'bx;
  endtask

  // One clock cycle: sample at negedge, model memory, drop req on ready, return at posedge+1.
  task automatic step();
    logic [127:0] rd0;
    bit r0, r1;
    r0 = 0; r1 = 0; rd0 = '0;
    @(negedge clock);
    if (cyc < 64) busy_log[cyc] = busy0;
    if (bus0.mem_read_enable && bus0.mem_write_enable) n_both++;
    if (bus0.mem_read_enable) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      rd_addr = bus0.mem_address;
      rd0 = mem0[bus0.mem_address[11:4]];
      r0 = 1;
    end
    if (bus0.mem_write_enable) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      wr_addr = bus0.mem_address;
      wr_data = bus0.mem_data_in;
      mem0[bus0.mem_address[11:4]] = bus0.mem_data_in;
    end
    if (bus0.dc_ready) begin
      n_dcr++;
      if (first_dcr < 0) first_dcr = cyc;
      bus0.dc_req = 1'b0;
    end
    if (bus0.ic_ready) begin
      n_icr++;
      if (first_icr < 0) first_icr = cyc;
      bus0.ic_req = 1'b0;
    end
    if (bus1.mem_read_enable) begin
      if (first_rd1 < 0) first_rd1 = cyc;
      r1 = 1;
    end
    if (bus1.dc_ready) begin
      if (first_dcr1 < 0) first_dcr1 = cyc;
      bus1.dc_req = 1'b0;
    end
    cyc++;
    @(posedge clock);
    #1;
    if (r0) bus0.mem_data_out = rd0;
    if (r1) bus1.mem_data_out = LINE_1;
  endtask

  task automatic dc_start(input logic we, input logic [11:0] addr, input logic [127:0] wdata);
    bus0.dc_req = 1'b1; bus0.dc_we = we; bus0.dc_addr = addr; bus0.dc_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = '0;
    mem0[1] = LINE_A;
    n_both = 0;
    clear_log();
    reset = 1'b1;
    bus0.ic_req = 0; bus0.ic_addr = '0; bus0.dc_req = 0; bus0.dc_we = 0;
    bus0.dc_addr = '0; bus0.dc_wdata = '0; bus0.mem_data_out = '0;
    bus1.ic_req = 0; bus1.ic_addr = '0; bus1.dc_req = 0; bus1.dc_we = 0;
    bus1.dc_addr = '0; bus1.dc_wdata = '0; bus1.mem_data_out = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy",      busy0, 0);
    chk("rst_ic_ready",  bus0.ic_ready, 0);
    chk("rst_dc_ready",  bus0.dc_ready, 0);
    chk("rst_rd_en",     bus0.mem_read_enable, 0);
    chk("rst_wr_en",     bus0.mem_write_enable, 0);
    chk("rst_ic_data",   bus0.ic_data, 0);
    chk("rst_dc_data",   bus0.dc_data, 0);
    chk("rst_mem_addr",  bus0.mem_address, 0);
    chk("rst_mem_din",   bus0.mem_data_in, 0);
    chk("rst_busy1",     busy1, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // dc read of an unaligned address
    clear_log();
    dc_start(1'b0, 12'h013, '0);
    for (int c = 0; c < 12; c++) step();
    chk("rd_strobe_cyc", first_rd, 6);
    chk("rd_strobe_cnt", n_rd, 1);
    chk("rd_no_write",   n_wr, 0);
    chk("rd_addr_align", rd_addr, 12'h010);
    chk("rd_ready_cyc",  first_dcr, 8);
    chk("rd_ready_cnt",  n_dcr, 1);
    chk("rd_dc_data",    bus0.dc_data, LINE_A);
    chk("rd_no_ic_rdy",  n_icr, 0);

    // dc writeback
    clear_log();
    dc_start(1'b1, 12'h020, LINE_A5);
    for (int c = 0; c < 12; c++) step();
    chk("wr_strobe_cyc", first_wr, 6);
    chk("wr_strobe_cnt", n_wr, 1);
    chk("wr_no_read",    n_rd, 0);
    chk("wr_addr",       wr_addr, 12'h020);
    chk("wr_data",       wr_data, LINE_A5);
    chk("wr_ready_cyc",  first_dcr, 8);
    chk("wr_keep_data",  bus0.dc_data, LINE_A);

    clear_log();
    dc_start(1'b0, 12'h020, '0);
    for (int c = 0; c < 12; c++) step();
    chk("rb_ready_cyc",  first_dcr, 8);
    chk("rb_dc_data",    bus0.dc_data, LINE_A5);

    // simultaneous requests: dc first, ic after
    clear_log();
    dc_start(1'b0, 12'h013, '0);
    bus0.ic_req = 1'b1; bus0.ic_addr = 12'h02C;
    for (int c = 0; c < 22; c++) step();
    chk("arb_dc_ready",  first_dcr, 8);
    chk("arb_idle_c9",   busy_log[9], 0);
    chk("arb_busy_c10",  busy_log[10], 1);
    chk("arb_ic_ready",  first_icr, 17);
    chk("arb_ic_cnt",    n_icr, 1);
    chk("arb_rd_cnt",    n_rd, 2);
    chk("arb_ic_data",   bus0.ic_data, LINE_A5);
    chk("arb_dc_data",   bus0.dc_data, LINE_A);

    // reset in cycle 4 of a dc read, request held
    clear_log();
    dc_start(1'b0, 12'h024, '0);
    for (int c = 0; c < 18; c++) begin
      if (c == 4) reset = 1'b1;
      if (c == 5) reset = 1'b0;
      step();
    end
    chk("rst_mid_busy4", busy_log[4], 1);
    chk("rst_mid_idle5", busy_log[5], 0);
    chk("rst_mid_rd_cyc", first_rd, 11);
    chk("rst_mid_rd_cnt", n_rd, 1);
    chk("rst_mid_ready",  first_dcr, 13);
    chk("rst_mid_rdycnt", n_dcr, 1);
    chk("rst_mid_data",   bus0.dc_data, LINE_A5);

    // request dropped after accept
    clear_log();
    dc_start(1'b0, 12'h01F, '0);
    for (int c = 0; c < 16; c++) begin
      if (c == 2) bus0.dc_req = 1'b0;
      step();
    end
    chk("drop_ready_cyc", first_dcr, 8);
    chk("drop_ready_cnt", n_dcr, 1);
    chk("drop_rd_cnt",    n_rd, 1);
    chk("drop_dc_data",   bus0.dc_data, LINE_A);

    // minimum latency instance
    clear_log();
    bus1.dc_req = 1'b1; bus1.dc_we = 1'b0; bus1.dc_addr = 12'h035;
    for (int c = 0; c < 8; c++) step();
    chk("lat1_rd_cyc",    first_rd1, 2);
    chk("lat1_ready_cyc", first_dcr1, 4);
    chk("lat1_dc_data",   bus1.dc_data, LINE_1);
    chk("lat1_addr",      bus1.mem_address, 12'h030);

    chk("never_both_strobes", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
